rx_cmd_ctrl_p: RTL
==================

// Module: rx_cmd_ctrl_p
// PURPOSE
//  Parametrised next-generation RX streaming command controller between the settings bus and the DDC/framer.
//  Queues timed or immediate stream commands, gates the DDC run/eob, and supports chain/reload and HALT.
//  Reports overrun, broken-chain, late-command and command-FIFO-overflow errors as 3-beat AXI-stream packets.
//  Late-command handling is selectable; FIFO depth and line-counter width are configurable.
// PARAMETERS
//  BASE        0   settings-bus base address (uses BASE..BASE+3)
//  LINES_W     28  width of numlines / line counters (1..28)
//  CMD_FIFO_LG 5   log2 command FIFO depth (depth = 2**CMD_FIFO_LG)
//  LATE_RUN    0   0: late timed command -> LATE error, dropped; 1: run it immediately, no error
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   asynchronous active-low reset
//  clear          in   1   synchronous clear: FSM to IDLE, command FIFO and pending flags emptied
//  set_stb        in   1   settings strobe
//  set_addr       in   8   settings address
//  set_data       in   32  settings data
//  vita_time      in   64  current time
//  strobe         in   1   DDC sample-line strobe
//  full           in   1   framer full (sampled with strobe)
//  seqnum         in   12  sequence number for error header
//  sid            in   32  stream ID for error header
//  run            out  1   high while RUNNING
//  eob            out  1   end-of-burst, coincident with last strobe of a burst
//  err_tdata      out  64  error packet data
//  err_tlast      out  1   last beat of error packet
//  err_tvalid     out  1   error packet valid
//  err_tready     in   1   error packet ready
//  state          out  3   FSM state (debug)
//  cmd_occupied   out  CMD_FIFO_LG+1  entries in command FIFO
// BEHAVIOUR
//  Reset: reset_n low -> asynchronously run=0, eob=0, err_tvalid=0, err_tlast=0, err_tdata=0,
//    state=IDLE, cmd_occupied=0, halt/overflow flags=0; clear does same synchronously.
//  Settings: BASE = {send_imm,chain,reload,stop,pad,numlines[LINES_W-1:0]} (bits 31..28 flags);
//    BASE+1 = time[63:32]; BASE+2 = time[31:0], write pushes {cmd,time} into FIFO;
//    BASE+3 any write sets halt. Push when FIFO full: entry dropped, ovf_pend set.
//  Head compare (combinational vs vita_time): now = (t==vita_time), late = (vita_time>t).
//  FSM states: IDLE, RUNNING, ERR_HDR, ERR_TIME, ERR_DATA; err_code reg latched on entry to ERR_HDR.
//  IDLE: priority ovf_pend (-> ERR_HDR code 0x10, clear ovf_pend) > halt (pop all, clear halt)
//    > head valid: stop -> pop, stay; late&~send_imm -> pop, LATE_RUN ? RUNNING : ERR_HDR code 0x2;
//    now|send_imm -> pop, RUNNING, lines_left=repeat=numlines, latch chain/reload.
//  numlines==0 popped in IDLE: dropped, no run, no error.
//  RUNNING on strobe: full -> ERR_HDR code 0x8 (no eob); lines_left>1 -> decrement;
//    lines_left==1: halt -> IDLE, flush FIFO, clear halt;
//    chain & head valid -> pop, reload counters/flags; head stop -> IDLE;
//    chain & no head & reload -> lines_left=repeat; chain & neither -> ERR_HDR code 0x4; else IDLE.
//  eob = strobe & run & lines_left==1 & ~full & (halt | ~chain | (head valid & stop) | (~head valid & ~reload)).
//  Error packet, each beat held until err_tvalid&err_tready (stall indefinitely, no drop):
//    beat0 {4'hA,seqnum,16'd24,sid}; beat1 vita_time captured on ERR_HDR entry; beat2 {err_code,32'd0}, tlast=1.
//    After beat2 -> IDLE. err_tvalid=1 only in ERR_* states; outputs registered.
//  ovf_pend set any state (including during error emission); emitted next IDLE visit. Simultaneous push+pop
//    on full FIFO: pop first, push accepted. Halt write concurrent with last line: halt wins.
//  Latency: command accepted in IDLE -> run=1 next cycle.
// TESTING
//  send_imm,numlines=4, 4 strobes -> run 4 strobes, eob on 4th, back to IDLE, no error packet.
//  Timed cmd t=1000, vita_time 990 -> run rises cycle after vita_time==1000; t=500 at 990 -> LATE pkt code 0x2 (LATE_RUN=0), run (LATE_RUN=1).
//  full asserted on 2nd strobe of 10-line burst -> 3-beat packet, beat2=0x00000008_00000000, tlast on beat2, run=0.
//  chain,numlines=3, FIFO empty, reload=0 -> BROKENCHAIN code 0x4; reload=1 -> repeats 3 lines, no eob.
//  Push 2**CMD_FIFO_LG+1 commands while idle-blocked -> one 0x10 packet, cmd_occupied max; err_tready low 20 cycles -> beats held stable.
//  HALT during chained reload stream -> eob on next last line, run=0, cmd_occupied=0; reset_n pulse mid-packet -> err_tvalid=0 immediately.

Source files
------------

// File: rtl/rx_cmd_ctrl_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : rx_cmd_ctrl_p_if
//  Purpose  : Bundles the settings bus, timing/DDC inputs, DDC gating outputs
//             and the error AXI-stream of rx_cmd_ctrl_p into one interface.
//  Modports : slave  - controller side (consumes settings, drives run/eob/err)
//             master - environment side (drives settings, consumes outputs)
//  Signals  : clear, set_stb, set_addr[7:0], set_data[31:0], vita_time[63:0],
//             strobe, full, seqnum[11:0], sid[31:0], err_tready   (to ctrl)
//             run, eob, err_tdata[63:0], err_tlast, err_tvalid, state[2:0],
//             cmd_occupied[CMD_FIFO_LG:0]                        (from ctrl)
//  Revision : 1.0 - initial release
// ============================================================================
interface rx_cmd_ctrl_p_if #(
    parameter int CMD_FIFO_LG = 5
);
    logic                   clear;
    logic                   set_stb;
    logic [7:0]             set_addr;
    logic [31:0]            set_data;
    logic [63:0]            vita_time;
    logic                   strobe;
    logic                   full;
    logic [11:0]            seqnum;
    logic [31:0]            sid;
    logic                   run;
    logic                   eob;
    logic [63:0]            err_tdata;
    logic                   err_tlast;
    logic                   err_tvalid;
    logic                   err_tready;
    logic [2:0]             state;
    logic [CMD_FIFO_LG:0]   cmd_occupied;

    modport slave (
        input  clear, set_stb, set_addr, set_data, vita_time, strobe, full,
               seqnum, sid, err_tready,
        output run, eob, err_tdata, err_tlast, err_tvalid, state, cmd_occupied
    );

    modport master (
        output clear, set_stb, set_addr, set_data, vita_time, strobe, full,
               seqnum, sid, err_tready,
        input  run, eob, err_tdata, err_tlast, err_tvalid, state, cmd_occupied
    );
endinterface
`default_nettype wire

// File: rtl/rx_cmd_ctrl_p.sv
`default_nettype none
// ============================================================================
//  Module   : rx_cmd_ctrl_p
//  Purpose  : RX streaming command controller. Queues timed/immediate stream
//             commands written over the settings bus, gates the DDC run/eob,
//             supports chain/reload and HALT, and reports overrun, broken
//             chain, late command and command-FIFO overflow as 3-beat error
//             packets on an AXI-stream.
//  Ports    : clk      - clock
//             reset_n  - asynchronous active-low reset
//             bus      - rx_cmd_ctrl_p_if.slave (settings, timing, DDC, error
//                        stream, debug state and FIFO occupancy)
//  Revision : 1.0 - initial release
// ============================================================================
module rx_cmd_ctrl_p #(
    parameter int BASE        = 0,
    parameter int LINES_W     = 28,
    parameter int CMD_FIFO_LG = 5,
    parameter int LATE_RUN    = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    rx_cmd_ctrl_p_if.slave  bus
);

    // FIFO entry layout: {send_imm, chain, reload, stop, numlines, time[63:0]}
    localparam int                   c_ent_w   = 4 + LINES_W + 64;
    localparam int unsigned          c_depth_i = 2 ** CMD_FIFO_LG;
    localparam logic [CMD_FIFO_LG:0] c_depth   = c_depth_i[CMD_FIFO_LG:0];
    localparam logic [7:0]           c_addr_cmd  = 8'(BASE);
    localparam logic [7:0]           c_addr_thi  = 8'(BASE + 1);
    localparam logic [7:0]           c_addr_tlo  = 8'(BASE + 2);
    localparam logic [7:0]           c_addr_halt = 8'(BASE + 3);
    localparam logic [31:0]          c_code_late  = 32'h0000_0002;
    localparam logic [31:0]          c_code_chain = 32'h0000_0004;
    localparam logic [31:0]          c_code_ovr   = 32'h0000_0008;
    localparam logic [31:0]          c_code_ovf   = 32'h0000_0010;
    localparam logic [LINES_W-1:0]   c_line_one   = LINES_W'(1);
    localparam logic [CMD_FIFO_LG-1:0] c_ptr_one  = CMD_FIFO_LG'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUNNING  = 3'd1,
        S_ERR_HDR  = 3'd2,
        S_ERR_TIME = 3'd3,
        S_ERR_DATA = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [31:0]            r_cmd_word;
    logic [31:0]            r_time_hi;
    logic [c_ent_w-1:0]     r_mem [c_depth_i];
    logic [CMD_FIFO_LG-1:0] r_wr_ptr;
    logic [CMD_FIFO_LG-1:0] r_rd_ptr;
    logic [CMD_FIFO_LG:0]   r_count;
    logic                   r_halt;
    logic                   r_ovf;
    logic [LINES_W-1:0]     r_lines_left;
    logic [LINES_W-1:0]     r_repeat;
    logic                   r_chain;
    logic                   r_reload;
    logic [31:0]            r_err_code;
    logic [63:0]            r_err_time;
    logic [63:0]            r_tdata;
    logic                   r_tvalid;
    logic                   r_tlast;

    // ------------------------------------------------------------------
    // Settings decode
    // ------------------------------------------------------------------
    logic w_wr_cmd, w_wr_thi, w_push_req, w_halt_wr;
    assign w_wr_cmd   = bus.set_stb & (bus.set_addr == c_addr_cmd);
    assign w_wr_thi   = bus.set_stb & (bus.set_addr == c_addr_thi);
    assign w_push_req = bus.set_stb & (bus.set_addr == c_addr_tlo);
    assign w_halt_wr  = bus.set_stb & (bus.set_addr == c_addr_halt);

    logic [c_ent_w-1:0] w_new_entry;
    assign w_new_entry = {r_cmd_word[31:28], r_cmd_word[LINES_W-1:0],
                          r_time_hi, bus.set_data};

    // ------------------------------------------------------------------
    // Head of command FIFO and time comparison
    // ------------------------------------------------------------------
    logic [c_ent_w-1:0] w_head;
    logic               w_head_valid;
    logic [63:0]        w_head_time;
    logic [LINES_W-1:0] w_head_lines;
    logic               w_head_stop, w_head_reload, w_head_chain, w_head_imm;
    logic               w_now, w_late;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_valid  = (r_count != '0);
    assign w_head_time   = w_head[63:0];
    assign w_head_lines  = w_head[64 +: LINES_W];
    assign w_head_stop   = w_head[64 + LINES_W];
    assign w_head_reload = w_head[65 + LINES_W];
    assign w_head_chain  = w_head[66 + LINES_W];
    assign w_head_imm    = w_head[67 + LINES_W];
    assign w_now         = (w_head_time == bus.vita_time);
    assign w_late        = (bus.vita_time > w_head_time);

    // A halt written in the same cycle as the last line already takes effect.
    logic w_halt;
    assign w_halt = r_halt | w_halt_wr;

    logic w_late_err, w_go;
    assign w_late_err = w_late & ~w_head_imm & (LATE_RUN == 0);
    assign w_go       = w_now | w_head_imm | (w_late & (LATE_RUN != 0));

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    logic        w_pop, w_flush, w_halt_clr, w_ovf_clr;
    logic        w_load, w_rep, w_dec, w_code_ld;
    logic [31:0] w_code_val;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_halt_clr  = 1'b0;
        w_ovf_clr   = 1'b0;
        w_load      = 1'b0;
        w_rep       = 1'b0;
        w_dec       = 1'b0;
        w_code_ld   = 1'b0;
        w_code_val  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_ovf) begin
                    w_state_nxt = S_ERR_HDR;
                    w_code_ld   = 1'b1;
                    w_code_val  = c_code_ovf;
                    w_ovf_clr   = 1'b1;
                end else if (w_halt) begin
                    w_flush    = 1'b1;
                    w_halt_clr = 1'b1;
                end else if (w_head_valid) begin
                    if (w_head_stop) begin
                        w_pop = 1'b1;
                    end else if (w_late_err || w_go) begin
                        w_pop = 1'b1;
                        // Zero-length commands are silently discarded.
                        if (w_head_lines == '0) begin
                            w_state_nxt = S_IDLE;
                        end else if (w_late_err) begin
                            w_state_nxt = S_ERR_HDR;
                            w_code_ld   = 1'b1;
                            w_code_val  = c_code_late;
                        end else begin
                            w_state_nxt = S_RUNNING;
                            w_load      = 1'b1;
                        end
                    end
                end
            end
            S_RUNNING: begin
                if (bus.strobe) begin
                    if (bus.full) begin
                        w_state_nxt = S_ERR_HDR;
                        w_code_ld   = 1'b1;
                        w_code_val  = c_code_ovr;
                    end else if (r_lines_left > c_line_one) begin
                        w_dec = 1'b1;
                    end else if (w_halt) begin
                        w_state_nxt = S_IDLE;
                        w_flush     = 1'b1;
                        w_halt_clr  = 1'b1;
                    end else if (r_chain && w_head_valid) begin
                        w_pop = 1'b1;
                        if (w_head_stop || (w_head_lines == '0)) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_load = 1'b1;
                        end
                    end else if (r_chain && r_reload) begin
                        w_rep = 1'b1;
                    end else if (r_chain) begin
                        w_state_nxt = S_ERR_HDR;
                        w_code_ld   = 1'b1;
                        w_code_val  = c_code_chain;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_ERR_HDR: begin
                if (bus.err_tready) w_state_nxt = S_ERR_TIME;
            end
            S_ERR_TIME: begin
                if (bus.err_tready) w_state_nxt = S_ERR_DATA;
            end
            S_ERR_DATA: begin
                if (bus.err_tready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command FIFO. A pop in the same cycle frees room for a push on a full
    // FIFO; a flush keeps a push arriving in that same cycle.
    // ------------------------------------------------------------------
    logic w_push_ok, w_wr_en;
    assign w_push_ok = w_push_req & ((r_count != c_depth) | w_pop);
    assign w_wr_en   = w_push_req & (w_push_ok | w_flush) & ~bus.clear;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_new_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= r_wr_ptr;
            if (w_push_req) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_count  <= (CMD_FIFO_LG+1)'(1);
            end else begin
                r_count  <= '0;
            end
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_count <= r_count + {{CMD_FIFO_LG{1'b0}}, w_push_ok}
                               - {{CMD_FIFO_LG{1'b0}}, w_pop};
        end
    end

    // ------------------------------------------------------------------
    // Settings registers and pending flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_word <= '0;
            r_time_hi  <= '0;
        end else begin
            if (w_wr_cmd) r_cmd_word <= bus.set_data;
            if (w_wr_thi) r_time_hi  <= bus.set_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_halt <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (bus.clear) begin
            r_halt <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_halt_clr)     r_halt <= 1'b0;
            else if (w_halt_wr) r_halt <= 1'b1;
            // A new overflow outranks consumption of an older one.
            if (w_push_req && !w_push_ok && !w_flush) r_ovf <= 1'b1;
            else if (w_ovf_clr)                       r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State, burst counters, error capture and registered stream outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_lines_left <= '0;
            r_repeat     <= '0;
            r_chain      <= 1'b0;
            r_reload     <= 1'b0;
            r_err_code   <= '0;
            r_err_time   <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
        end else if (bus.clear) begin
            r_state      <= S_IDLE;
            r_lines_left <= '0;
            r_repeat     <= '0;
            r_chain      <= 1'b0;
            r_reload     <= 1'b0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_lines_left <= w_head_lines;
                r_repeat     <= w_head_lines;
                r_chain      <= w_head_chain;
                r_reload     <= w_head_reload;
            end else if (w_rep) begin
                r_lines_left <= r_repeat;
            end else if (w_dec) begin
                r_lines_left <= r_lines_left - c_line_one;
            end
            if (w_code_ld) begin
                r_err_code <= w_code_val;
                r_err_time <= bus.vita_time;
            end
            r_tvalid <= (w_state_nxt == S_ERR_HDR) || (w_state_nxt == S_ERR_TIME)
                     || (w_state_nxt == S_ERR_DATA);
            r_tlast  <= (w_state_nxt == S_ERR_DATA);
            // Beat data is only loaded on a state change so it stays stable
            // while the consumer stalls.
            if (w_state_nxt != r_state) begin
                case (w_state_nxt)
                    S_ERR_HDR:  r_tdata <= {4'hA, bus.seqnum, 16'd24, bus.sid};
                    S_ERR_TIME: r_tdata <= r_err_time;
                    S_ERR_DATA: r_tdata <= {r_err_code, 32'd0};
                    default:    r_tdata <= '0;
                endcase
            end
        end
    end

    logic w_run;
    assign w_run = (r_state == S_RUNNING);

    assign bus.run          = w_run;
    assign bus.eob          = bus.strobe & w_run & (r_lines_left == c_line_one) & ~bus.full
                            & (w_halt | ~r_chain | (w_head_valid & w_head_stop)
                               | (~w_head_valid & ~r_reload));
    assign bus.err_tdata    = r_tdata;
    assign bus.err_tvalid   = r_tvalid;
    assign bus.err_tlast    = r_tlast;
    assign bus.state        = r_state;
    assign bus.cmd_occupied = r_count;

endmodule
`default_nettype wire
